// File: rtl/ldpc_pkg.sv
// Shared types, constants and the CRC-32 word update for the LDPC output framer.
// The CRC helper is only referenced when FRAME_CRC_EN is defined.
package ldpc_pkg;

  typedef enum logic [2:0] {IDLE, SYNC, HDR, PAYLOAD, CRC} frame_state_t;

  localparam int          CW_BITS             = 648;
  localparam int          WORDS_PER_FRAME_DEF = 81;
  localparam logic [31:0] SYNC_WORD_DEF       = 32'h1ACF_FC1D;
  localparam logic [31:0] CRC32_POLY          = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT          = 32'hFFFF_FFFF;

  // MSB-first, non-reflected CRC-32 update over one 32-bit word.
  function automatic logic [31:0] crc32_word(input logic [31:0] crc, input logic [31:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      if (c[31] ^ data[i]) begin
        c = {c[30:0], 1'b0} ^ CRC32_POLY;
      end else begin
        c = {c[30:0], 1'b0};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/ldpc_frame_tx_sync_fifo.sv
// Single-clock FIFO with show-ahead read: rd_data always shows the head entry,
// so the framer can pop and register a word in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 128
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;

  // Extra pointer MSB distinguishes a full buffer from an empty one.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign count   = wr_ptr_reg - rd_ptr_reg;
  assign rd_data = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (rd_en) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/ldpc_frame_tx.sv
// Output framer: buffers converter words and emits sync/header/payload[/CRC] frames
// on an AXI4-Stream-style port. Define FRAME_CRC_EN to append a CRC-32 word.
module ldpc_frame_tx
  import ldpc_pkg::*;
#(
  parameter int          DATA_WIDTH      = 32,
  parameter int          WORDS_PER_FRAME = WORDS_PER_FRAME_DEF,
  parameter int          FIFO_DEPTH      = 128,
  parameter logic [31:0] SYNC_WORD       = SYNC_WORD_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  overflow
);

  localparam int                CNT_W    = $clog2(WORDS_PER_FRAME);
  localparam int                LVL_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(WORDS_PER_FRAME - 1);

  frame_state_t          state_reg, state_next;
  logic [DATA_WIDTH-1:0] tdata_reg, tdata_next;
  logic                  tvalid_reg, tvalid_next;
  logic                  tlast_reg, tlast_next;
  logic                  final_reg, final_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [15:0]           seq_reg;
  logic                  overflow_reg;

  logic                  accept;
  logic                  want_load;
  logic [CNT_W-1:0]      load_idx;
  logic                  frame_done;

  logic                  fifo_wr;
  logic                  fifo_rd;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [LVL_W-1:0]      fifo_count;

`ifdef FRAME_CRC_EN
  logic [31:0]           crc_reg, crc_next;
  logic [31:0]           crc_upd;
  assign crc_upd = crc32_word(crc_reg, tdata_reg);
`endif

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .srst    (rst),
    .wr_en   (fifo_wr),
    .wr_data (data_in),
    .rd_en   (fifo_rd),
    .rd_data (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign accept   = tvalid_reg && m_tready;
  // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
  assign fifo_wr  = valid_in && (!fifo_full || fifo_rd);
  assign m_tdata  = tdata_reg;
  assign m_tvalid = tvalid_reg;
  assign m_tlast  = tlast_reg;
  assign overflow = overflow_reg;

  always_comb begin
    state_next  = state_reg;
    tdata_next  = tdata_reg;
    tvalid_next = tvalid_reg;
    tlast_next  = tlast_reg;
    final_next  = final_reg;
    cnt_next    = cnt_reg;
    fifo_rd     = 1'b0;
    frame_done  = 1'b0;
    want_load   = 1'b0;
    load_idx    = cnt_reg;
`ifdef FRAME_CRC_EN
    crc_next    = crc_reg;
`endif
    unique case (state_reg)
      IDLE: begin
        if (fifo_count != '0) begin
          state_next  = SYNC;
          tdata_next  = SYNC_WORD;
          tvalid_next = 1'b1;
          tlast_next  = 1'b0;
        end
      end
      SYNC: begin
`ifdef FRAME_CRC_EN
        crc_next = CRC32_INIT;
`endif
        if (accept) begin
          state_next = HDR;
          tdata_next = {seq_reg, 16'(WORDS_PER_FRAME)};
        end
      end
      HDR: begin
        if (accept) begin
          state_next = PAYLOAD;
          want_load  = 1'b1;
          load_idx   = '0;
        end
      end
      PAYLOAD: begin
`ifdef FRAME_CRC_EN
        if (accept) begin
          crc_next = crc_upd;
        end
`endif
        // final_reg marks that the output register holds the last payload word.
        if (final_reg) begin
          if (accept) begin
            final_next = 1'b0;
`ifdef FRAME_CRC_EN
            state_next  = CRC;
            tdata_next  = crc_upd ^ 32'hFFFF_FFFF;
            tvalid_next = 1'b1;
            tlast_next  = 1'b1;
`else
            state_next  = IDLE;
            tvalid_next = 1'b0;
            tlast_next  = 1'b0;
            frame_done  = 1'b1;
`endif
          end
        end else if (!tvalid_reg || m_tready) begin
          want_load = 1'b1;
        end
      end
`ifdef FRAME_CRC_EN
      CRC: begin
        if (accept) begin
          state_next  = IDLE;
          tvalid_next = 1'b0;
          tlast_next  = 1'b0;
          frame_done  = 1'b1;
        end
      end
`endif
      default: state_next = IDLE;
    endcase

    if (want_load) begin
      if (!fifo_empty) begin
        fifo_rd     = 1'b1;
        tdata_next  = fifo_dout;
        tvalid_next = 1'b1;
        final_next  = (load_idx == LAST_IDX);
`ifdef FRAME_CRC_EN
        tlast_next  = 1'b0;
`else
        tlast_next  = (load_idx == LAST_IDX);
`endif
        cnt_next    = load_idx + CNT_W'(1);
      end else begin
        // Underrun mid-frame: idle the bus and resume with the same index.
        tvalid_next = 1'b0;
        tlast_next  = 1'b0;
        cnt_next    = load_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      tdata_reg  <= '0;
      tvalid_reg <= 1'b0;
      tlast_reg  <= 1'b0;
      final_reg  <= 1'b0;
      cnt_reg    <= '0;
`ifdef FRAME_CRC_EN
      crc_reg    <= CRC32_INIT;
`endif
    end else begin
      state_reg  <= state_next;
      tdata_reg  <= tdata_next;
      tvalid_reg <= tvalid_next;
      tlast_reg  <= tlast_next;
      final_reg  <= final_next;
      cnt_reg    <= cnt_next;
`ifdef FRAME_CRC_EN
      crc_reg    <= crc_next;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_reg      <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (frame_done) begin
        seq_reg <= seq_reg + 16'd1;
      end
      if (valid_in && fifo_full && !fifo_rd) begin
        overflow_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ldpc_frame_tx.sv
// Directed bench for ldpc_frame_tx: frame content, stalls, seq, overflow, reset, CRC.
module tb_ldpc_frame_tx;

  localparam int WPF = 81;
`ifdef FRAME_CRC_EN
  localparam int FRAME_LEN = WPF + 3;
`else
  localparam int FRAME_LEN = WPF + 2;
`endif

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [31:0] data_in;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        overflow;

  int total_cnt = 0;
  int bad_cnt   = 0;

  logic [31:0] fr_words[$];
  int          fr_first_k;
  int          fr_cycles;
  int          fr_timeout;
  int          fr_unstable;

  ldpc_frame_tx dut (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .data_in  (data_in),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_crc(input int base, input int step, input int n);
    logic [31:0] c;
    logic [31:0] w;
    logic [7:0]  b;
    c = 32'hFFFF_FFFF;
    for (int j = 0; j < n; j++) begin
      w = 32'(base + step * j);
      for (int k = 3; k >= 0; k--) begin
        b = w[8*k +: 8];
        c = c ^ {b, 24'h0};
        for (int s = 0; s < 8; s++) begin
          c = c[31] ? ({c[30:0], 1'b0} ^ 32'h04C1_1DB7) : {c[30:0], 1'b0};
        end
      end
    end
    return ~c;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    valid_in = 1'b0;
    m_tready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_burst(input int base, input int step, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid_in = 1'b1;
      data_in  = 32'(base + step * i);
    end
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  // Drives m_tready each negedge and records accepted beats until one carries m_tlast.
  task automatic collect_frame(input bit toggle, input int budget);
    bit          phase = 1'b1;
    bit          stall = 1'b0;
    bit          done  = 1'b0;
    logic [31:0] pdata = '0;
    logic        plast = 1'b0;
    int          k     = 0;
    fr_words.delete();
    fr_first_k  = -1;
    fr_cycles   = 0;
    fr_timeout  = 0;
    fr_unstable = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      if (stall && !(m_tvalid === 1'b1 && m_tdata === pdata && m_tlast === plast)) begin
        fr_unstable++;
      end
      m_tready = toggle ? phase : 1'b1;
      phase    = !phase;
      if (m_tvalid === 1'b1) begin
        if (fr_first_k < 0) fr_first_k = k;
        if (m_tready) begin
          fr_words.push_back(m_tdata);
          stall = 1'b0;
          if (m_tlast === 1'b1) begin
            done      = 1'b1;
            fr_cycles = k - fr_first_k + 1;
          end
        end else begin
          stall = 1'b1;
          pdata = m_tdata;
          plast = m_tlast;
        end
      end else begin
        stall = 1'b0;
      end
      k++;
    end
    if (!done) fr_timeout = 1;
  endtask

  task automatic check_frame(input string tag, input logic [31:0] hdr, input int base, input int step);
    int nbad = 0;
    chk_val({tag, "_timeout"}, 32'(fr_timeout), 32'd0);
    chk_val({tag, "_len"}, 32'(fr_words.size()), 32'(FRAME_LEN));
    if (fr_words.size() == FRAME_LEN) begin
      chk_val({tag, "_sync"}, fr_words[0], 32'h1ACF_FC1D);
      chk_val({tag, "_hdr"}, fr_words[1], hdr);
      for (int j = 0; j < WPF; j++) begin
        if (fr_words[j+2] !== 32'(base + step * j)) nbad++;
      end
      chk_val({tag, "_payload_bad"}, 32'(nbad), 32'd0);
      chk_val({tag, "_pay80"}, fr_words[WPF+1], 32'(base + step * (WPF - 1)));
`ifdef FRAME_CRC_EN
      chk_val({tag, "_crc"}, fr_words[WPF+2], ref_crc(base, step, WPF));
`endif
    end
    chk_val({tag, "_stall_hold"}, 32'(fr_unstable), 32'd0);
    $display("frame %s: words=%0d cycles=%0d", tag, fr_words.size(), fr_cycles);
  endtask

  initial begin
    int beats;
    rst      = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    m_tready = 1'b0;
    repeat (3) @(negedge clk);
    chk_val("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk_val("rst_tlast", 32'(m_tlast), 32'd0);
    chk_val("rst_tdata", m_tdata, 32'd0);
    chk_val("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;

    // Basic frame with m_tready held high.
    fork
      send_burst(0, 1, WPF);
      collect_frame(1'b0, 400);
    join
    check_frame("t1", 32'h0000_0051, 0, 1);
    chk_val("t1_latency", 32'(fr_first_k), 32'd2);
    chk_val("t1_cycles", 32'(fr_cycles), 32'(FRAME_LEN));
    chk_val("t1_overflow", 32'(overflow), 32'd0);

    // Same data with m_tready toggling every cycle.
    fork
      send_burst(0, 1, WPF);
      collect_frame(1'b1, 600);
    join
    check_frame("t2", 32'h0001_0051, 0, 1);
    chk_val("t2_cycles_range", 32'(fr_cycles >= 160 && fr_cycles <= 170), 32'd1);

    // Three back-to-back bursts, then sequence wrap.
    do_reset();
    fork
      send_burst(0, 1, 3 * WPF);
      begin
        for (int f = 0; f < 3; f++) begin
          collect_frame(1'b0, 400);
          check_frame($sformatf("t3_f%0d", f), {16'(f), 16'h0051}, WPF * f, 1);
        end
      end
    join
    repeat (3) @(negedge clk);
    force dut.seq_reg = 16'hFFFF;
    @(negedge clk);
    release dut.seq_reg;
    fork
      send_burst(1000, 1, WPF);
      collect_frame(1'b0, 400);
    join
    check_frame("t3_wrap", 32'hFFFF_0051, 1000, 1);
    fork
      send_burst(2000, 1, WPF);
      collect_frame(1'b0, 400);
    join
    check_frame("t3_after_wrap", 32'h0000_0051, 2000, 1);

    // Overflow with the sink stalled.
    do_reset();
    for (int i = 0; i < 130; i++) begin
      @(negedge clk);
      if (i == 128) chk_val("t4_ovf_before_drop", 32'(overflow), 32'd0);
      if (i == 129) chk_val("t4_ovf_after_drop", 32'(overflow), 32'd1);
      valid_in = 1'b1;
      data_in  = 32'(i);
    end
    @(negedge clk);
    valid_in = 1'b0;
    repeat (3) @(negedge clk);
    chk_val("t4_ovf_sticky", 32'(overflow), 32'd1);
    collect_frame(1'b0, 400);
    check_frame("t4", 32'h0000_0051, 0, 1);
    chk_val("t4_ovf_after_frame", 32'(overflow), 32'd1);

    // Reset in the middle of a frame.
    do_reset();
    send_burst(500, 1, WPF);
    beats = 0;
    for (int k = 0; k < 300 && beats < 43; k++) begin
      @(negedge clk);
      m_tready = 1'b1;
      if (m_tvalid === 1'b1) beats++;
    end
    chk_val("t5_beats_reached", 32'(beats), 32'd43);
    rst = 1'b1;
    @(negedge clk);
    chk_val("t5_rst_tvalid", 32'(m_tvalid), 32'd0);
    chk_val("t5_rst_tlast", 32'(m_tlast), 32'd0);
    chk_val("t5_rst_tdata", m_tdata, 32'd0);
    chk_val("t5_rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk_val("t5_fifo_flushed", 32'(m_tvalid), 32'd0);
    fork
      send_burst(700, 1, WPF);
      collect_frame(1'b0, 400);
    join
    check_frame("t5", 32'h0000_0051, 700, 1);

    // All-zero payload (CRC word checked when enabled).
    do_reset();
    fork
      send_burst(0, 0, WPF);
      collect_frame(1'b0, 400);
    join
    check_frame("t6_zero", 32'h0000_0051, 0, 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
